// File: rtl/ps2_ascii_decoder.sv
// PS/2 Set-2 scan-code to ASCII decoder with Shift/Caps tracking and a FWFT output FIFO.
// Optional Caps Lock handling is enabled by defining PS2_CAPS_LOCK_EN.
module ps2_ascii_decoder #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_code,
  input  logic       code_tick,
  input  logic       rd_en,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_active,
  output logic       caps_active
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t               state_q;
  logic                 lshift_q, rshift_q;
  logic                 push_req;
  logic [7:0]           push_char;
  logic [8:0]           xl;
  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q;
  logic                 overflow_q;
  logic                 empty, full, do_push, do_pop;

`ifdef PS2_CAPS_LOCK_EN
  logic caps_q, caps_held_q;
  assign caps_active = caps_q;
`else
  assign caps_active = 1'b0;
`endif

  assign shift_active = lshift_q | rshift_q;

  // Returns {hit, char}; up selects letter case, sh selects the shifted digit row.
  function automatic logic [8:0] xlate(input logic [7:0] c, input logic up, input logic sh);
    logic [7:0] l;
    logic [8:0] r;
    l = 8'h00;
    r = 9'h000;
    case (c)
      8'h1C: l = 8'h61; 8'h32: l = 8'h62; 8'h21: l = 8'h63; 8'h23: l = 8'h64;
      8'h24: l = 8'h65; 8'h2B: l = 8'h66; 8'h34: l = 8'h67; 8'h33: l = 8'h68;
      8'h43: l = 8'h69; 8'h3B: l = 8'h6A; 8'h42: l = 8'h6B; 8'h4B: l = 8'h6C;
      8'h3A: l = 8'h6D; 8'h31: l = 8'h6E; 8'h44: l = 8'h6F; 8'h4D: l = 8'h70;
      8'h15: l = 8'h71; 8'h2D: l = 8'h72; 8'h1B: l = 8'h73; 8'h2C: l = 8'h74;
      8'h3C: l = 8'h75; 8'h2A: l = 8'h76; 8'h1D: l = 8'h77; 8'h22: l = 8'h78;
      8'h35: l = 8'h79; 8'h1A: l = 8'h7A;
      default: l = 8'h00;
    endcase
    if (l != 8'h00) begin
      r = {1'b1, up ? (l & 8'hDF) : l};
    end else begin
      case (c)
        8'h45: r = {1'b1, sh ? 8'h29 : 8'h30};
        8'h16: r = {1'b1, sh ? 8'h21 : 8'h31};
        8'h1E: r = {1'b1, sh ? 8'h40 : 8'h32};
        8'h26: r = {1'b1, sh ? 8'h23 : 8'h33};
        8'h25: r = {1'b1, sh ? 8'h24 : 8'h34};
        8'h2E: r = {1'b1, sh ? 8'h25 : 8'h35};
        8'h36: r = {1'b1, sh ? 8'h5E : 8'h36};
        8'h3D: r = {1'b1, sh ? 8'h26 : 8'h37};
        8'h3E: r = {1'b1, sh ? 8'h2A : 8'h38};
        8'h46: r = {1'b1, sh ? 8'h28 : 8'h39};
        8'h29: r = {1'b1, 8'h20};
        8'h5A: r = {1'b1, 8'h0D};
        8'h66: r = {1'b1, 8'h08};
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    push_req  = 1'b0;
    push_char = 8'h00;
    xl        = xlate(ps2_code, shift_active ^ caps_active, shift_active);
    if (code_tick) begin
      case (state_q)
        IDLE: if (xl[8]) begin
          push_req  = 1'b1;
          push_char = xl[7:0];
        end
        EXT: if (ps2_code == 8'h5A) begin
          push_req  = 1'b1;
          push_char = 8'h0D;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
`endif
    end else if (code_tick) begin
      case (state_q)
        IDLE: begin
          case (ps2_code)
            8'hF0: state_q  <= BRK;
            8'hE0: state_q  <= EXT;
            8'h12: lshift_q <= 1'b1;
            8'h59: rshift_q <= 1'b1;
`ifdef PS2_CAPS_LOCK_EN
            // Typematic repeats arrive while held; only the first press toggles.
            8'h58: if (!caps_held_q) begin
              caps_q      <= ~caps_q;
              caps_held_q <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
        BRK: begin
          case (ps2_code)
            8'h12: lshift_q    <= 1'b0;
            8'h59: rshift_q    <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
            8'h58: caps_held_q <= 1'b0;
`endif
            default: ;
          endcase
          state_q <= IDLE;
        end
        EXT:     state_q <= (ps2_code == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Count's MSB is set exactly when occupancy equals DEPTH.
  assign empty   = (count_q == '0);
  assign full    = count_q[FIFO_AW];
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_req & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (push_req & full & ~do_pop) overflow_q <= 1'b1;
    end
  end

  assign ascii_out   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign ascii_valid = ~empty;
  assign fifo_full   = full;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Scoreboard bench for ps2_ascii_decoder: stimulus queues expected characters,
// a negedge monitor compares every FIFO pop against the queue.
module tb_ps2_ascii_decoder;

`ifdef PS2_CAPS_LOCK_EN
  localparam bit CAPS_EN = 1'b1;
`else
  localparam bit CAPS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ps2_code;
  logic       code_tick;
  logic       rd_en;
  logic [7:0] ascii_out;
  logic       ascii_valid, fifo_full, overflow, shift_active, caps_active;

  logic       rd_mon = 1'b0;
  logic       rd_stim = 1'b0;
  logic       drain = 1'b1;
  logic [7:0] exp_q [$];
  int         tests = 0;
  int         fails = 0;

  assign rd_en = rd_mon | rd_stim;

  ps2_ascii_decoder #(.FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .ps2_code(ps2_code), .code_tick(code_tick),
    .rd_en(rd_en), .ascii_out(ascii_out), .ascii_valid(ascii_valid),
    .fifo_full(fifo_full), .overflow(overflow), .shift_active(shift_active),
    .caps_active(caps_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop (drain-driven or stimulus-driven) is compared to the queue head.
  always @(negedge clk) begin
    logic [7:0] e;
    rd_mon = 1'b0;
    if (!reset && ascii_valid && (drain || rd_stim)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_char", {24'h0, ascii_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("fifo_head", {24'h0, ascii_out}, {24'h0, e});
      end
      rd_mon = drain;
    end
  end

  // Called at posedge+1; presents one code for one cycle.
  task automatic send(input logic [7:0] c, input logic pop = 1'b0);
    ps2_code  = c;
    code_tick = 1'b1;
    rd_stim   = pop;
    @(posedge clk); #1;
    code_tick = 1'b0;
    rd_stim   = 1'b0;
  endtask

  task automatic sendx(input logic [7:0] c, input logic [7:0] e);
    exp_q.push_back(e);
    send(c);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !ascii_valid) break;
      @(posedge clk); #1;
    end
    check(name, {31'h0, (exp_q.size() == 0 && !ascii_valid)}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; code_tick = 1'b0; ps2_code = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ascii_out", {24'h0, ascii_out}, 32'h0);
    check("rst_valid", {31'h0, ascii_valid}, 32'h0);
    check("rst_full", {31'h0, fifo_full}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_shift", {31'h0, shift_active}, 32'h0);
    check("rst_caps", {31'h0, caps_active}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Case and release
    sendx(8'h1C, 8'h61);
    check("latency_valid", {31'h0, ascii_valid}, 32'h1);
    check("latency_out", {24'h0, ascii_out}, 32'h61);
    send(8'h12);
    check("shift_on", {31'h0, shift_active}, 32'h1);
    sendx(8'h1C, 8'h41);
    sendx(8'h1A, 8'h5A);
    send(8'hF0); send(8'h12);
    sendx(8'h1C, 8'h61);
    sendx(8'h15, 8'h71);
    check("shift_off", {31'h0, shift_active}, 32'h0);

    // Caps Lock and typematic
    send(8'h58);
    check("caps_on", {31'h0, caps_active}, {31'h0, CAPS_EN});
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    check("caps_typematic", {31'h0, caps_active}, {31'h0, CAPS_EN});
    sendx(8'h1C, CAPS_EN ? 8'h41 : 8'h61);
    send(8'h59);
    sendx(8'h1C, CAPS_EN ? 8'h61 : 8'h41);
    send(8'hF0); send(8'h59); send(8'h58); send(8'hF0); send(8'h58);
    check("caps_off", {31'h0, caps_active}, 32'h0);
    check("rshift_off", {31'h0, shift_active}, 32'h0);

    // Digits and specials
    sendx(8'h16, 8'h31);
    sendx(8'h45, 8'h30);
    send(8'h12);
    sendx(8'h16, 8'h21);
    sendx(8'h36, 8'h5E);
    sendx(8'h29, 8'h20);
    sendx(8'h5A, 8'h0D);
    sendx(8'h66, 8'h08);
    send(8'hF0); send(8'h12);
    send(8'hE0); sendx(8'h5A, 8'h0D);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h0E);

    // Break codes
    send(8'hF0); send(8'h1C);
    sendx(8'h1C, 8'h61);
    wait_empty("drain_1");

    // Overflow with FIFO depth 4
    drain = 1'b0;
    sendx(8'h1C, 8'h61);
    sendx(8'h32, 8'h62);
    sendx(8'h21, 8'h63);
    check("not_full_3", {31'h0, fifo_full}, 32'h0);
    sendx(8'h23, 8'h64);
    check("full_4", {31'h0, fifo_full}, 32'h1);
    check("no_ovf_4", {31'h0, overflow}, 32'h0);
    send(8'h24);
    check("ovf_set", {31'h0, overflow}, 32'h1);
    check("full_after_drop", {31'h0, fifo_full}, 32'h1);
    exp_q.push_back(8'h66);
    send(8'h2B, 1'b1);
    check("full_push_pop", {31'h0, fifo_full}, 32'h1);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);
    drain = 1'b1;
    wait_empty("drain_2");
    rd_stim = 1'b1;
    @(posedge clk); #1;
    rd_stim = 1'b0;
    check("empty_pop_valid", {31'h0, ascii_valid}, 32'h0);
    check("empty_pop_full", {31'h0, fifo_full}, 32'h0);

    // Reset mid-sequence
    send(8'hF0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("rst2_overflow", {31'h0, overflow}, 32'h0);
    check("rst2_valid", {31'h0, ascii_valid}, 32'h0);
    sendx(8'h1C, 8'h61);
    check("rst2_out", {24'h0, ascii_out}, 32'h61);
    wait_empty("drain_3");
    check("final_overflow", {31'h0, overflow}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
